ring_seq_onehot: RTL

//  Parametrised one-hot ring sequencer: successor to the team's fixed 4-stage ring FSM.

---
 rtl/ring_seq_pkg.sv | 31 +++
 rtl/ring_lap_counter.sv | 34 +++
 rtl/ring_seq_onehot.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ring_seq_pkg.sv
// Shared types, direction constants and index-width helpers for the one-hot ring sequencer.
package ring_seq_pkg;

   localparam logic DIR_FWD = 1'b0;
   localparam logic DIR_REV = 1'b1;

   typedef enum logic [2:0] {
      OP_HOLD,
      OP_LOAD,
      OP_LOAD_ERR,
      OP_FWD,
      OP_REV
   } ring_op_e;

   function automatic int clog2(input int unsigned n);
      int          r;
      int unsigned v;
      r = 0;
      v = 1;
      while (v < n) begin
         v = v << 1;
         r++;
      end
      return r;
   endfunction

   function automatic int idx_width(input int unsigned stages);
      return (clog2(stages) < 1) ? 1 : clog2(stages);
   endfunction

endpackage

// File: rtl/ring_lap_counter.sv
// Signed-modular lap counter: +1 per forward wrap, -1 per reverse wrap, sync active-low reset.
module ring_lap_counter #(
   parameter int LAPW = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            inc,
   input  logic            dec,
   output logic [LAPW-1:0] lap
);

   logic [LAPW-1:0] lap_q;
   logic [LAPW-1:0] lap_d;

   always_comb begin
      lap_d = lap_q;
      if (inc && !dec) begin
         lap_d = lap_q + LAPW'(1);
      end else if (dec && !inc) begin
         lap_d = lap_q - LAPW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         lap_q <= '0;
      end else begin
         lap_q <= lap_d;
      end
   end

   assign lap = lap_q;

endmodule

// File: rtl/ring_seq_onehot.sv
// Parametrised one-hot ring sequencer with step, load, wrap pulse and binary index.
// Optional lap counter port is built only when RING_LAP_CNT_EN is defined.
module ring_seq_onehot
   import ring_seq_pkg::*;
#(
   parameter int  STAGES      = 4,
   parameter int  RESET_STAGE = 0,
   parameter int  LAPW        = 8,
   localparam int IDXW        = idx_width(STAGES)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              dir,
   input  logic              load,
   input  logic [IDXW-1:0]   load_idx,
   output logic [STAGES-1:0] state,
   output logic [IDXW-1:0]   idx,
   output logic              wrap,
   output logic              load_err
`ifdef RING_LAP_CNT_EN
   ,
   output logic [LAPW-1:0]   lap
`endif
);

   localparam logic [IDXW-1:0]   LAST_IDX  = IDXW'(STAGES - 1);
   localparam logic [IDXW-1:0]   RST_IDX   = IDXW'(RESET_STAGE);
   localparam logic [STAGES-1:0] RST_STATE = STAGES'(1) << RESET_STAGE;

   if (STAGES < 2 || RESET_STAGE < 0 || RESET_STAGE >= STAGES || LAPW < 1) begin : g_param_check
      $error("ring_seq_onehot: illegal parameter set");
   end

   logic [IDXW-1:0]   idx_q,   idx_d;
   logic [STAGES-1:0] state_q, state_d;
   logic              wrap_q,  wrap_d;
   logic              lerr_q,  lerr_d;
   logic              load_ok;
   ring_op_e          op;

   // Zero-extend both sides so non-power-of-two rings reject out-of-range indices.
   assign load_ok = ({1'b0, load_idx} <= {1'b0, LAST_IDX});

   always_comb begin
      op = OP_HOLD;
      if (load) begin
         op = load_ok ? OP_LOAD : OP_LOAD_ERR;
      end else if (en) begin
         op = (dir == DIR_REV) ? OP_REV : OP_FWD;
      end
   end

   // Steps rotate the one-hot vector in step with idx, so only loads need a decode.
   always_comb begin
      idx_d   = idx_q;
      state_d = state_q;
      wrap_d  = 1'b0;
      lerr_d  = 1'b0;
      unique case (op)
         OP_LOAD: begin
            idx_d            = load_idx;
            state_d          = '0;
            state_d[load_idx] = 1'b1;
         end
         OP_LOAD_ERR: begin
            lerr_d = 1'b1;
         end
         OP_FWD: begin
            wrap_d  = (idx_q == LAST_IDX);
            idx_d   = wrap_d ? '0 : idx_q + IDXW'(1);
            state_d = {state_q[STAGES-2:0], state_q[STAGES-1]};
         end
         OP_REV: begin
            wrap_d  = (idx_q == '0);
            idx_d   = wrap_d ? LAST_IDX : idx_q - IDXW'(1);
            state_d = {state_q[0], state_q[STAGES-1:1]};
         end
         default: begin
            idx_d   = idx_q;
            state_d = state_q;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         idx_q   <= RST_IDX;
         state_q <= RST_STATE;
         wrap_q  <= 1'b0;
         lerr_q  <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         state_q <= state_d;
         wrap_q  <= wrap_d;
         lerr_q  <= lerr_d;
      end
   end

   assign state    = state_q;
   assign idx      = idx_q;
   assign wrap     = wrap_q;
   assign load_err = lerr_q;

`ifdef RING_LAP_CNT_EN
   logic lap_inc;
   logic lap_dec;

   assign lap_inc = wrap_d && (op == OP_FWD);
   assign lap_dec = wrap_d && (op == OP_REV);

   ring_lap_counter #(
      .LAPW (LAPW)
   ) u_lap (
      .clk   (clk),
      .reset (reset),
      .inc   (lap_inc),
      .dec   (lap_dec),
      .lap   (lap)
   );
`endif

endmodule
